ex_mem_stage: RTL and testbench

Execute/memory pipeline register for the MIPS-32 core. It sits directly downstream of the ALU and captures the ALU result, the zero flag and the forwarded control bits into the EX/MEM boundary. It resolves BEQ using the ALU zero flag, computes the branch target, and squashes the wrong-path instructions that follow a taken branch. It also provides a stall/flush handshake toward the memory stage.

---
 rtl/ex_mem_stage_if.sv | 42 ++++
 rtl/ex_mem_stage.sv | 125 ++++++++++++
 tb/tb_ex_mem_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: EX-side inputs and stall/flush in, registered MEM-side fields out.
// The stage uses the slave modport; whoever drives the EX side uses master.
interface ex_mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic [31:0] alu_result;
  logic        zf;
  logic [3:0]  selector;
  logic [31:0] rt_data;
  logic [4:0]  wr_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic [31:0] pc_plus4;
  logic [31:0] imm_ext;
  logic        out_valid;
  logic [31:0] alu_result_q;
  logic [31:0] store_data_q;
  logic [4:0]  wr_reg_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        branch_taken;
  logic [31:0] branch_target;

  modport master (
    output in_valid, stall, flush, alu_result, zf, selector, rt_data, wr_reg,
           reg_write, mem_read, mem_write, branch, pc_plus4, imm_ext,
    input  in_ready, out_valid, alu_result_q, store_data_q, wr_reg_q,
           reg_write_q, mem_read_q, mem_write_q, branch_taken, branch_target
  );

  modport slave (
    input  in_valid, stall, flush, alu_result, zf, selector, rt_data, wr_reg,
           reg_write, mem_read, mem_write, branch, pc_plus4, imm_ext,
    output in_ready, out_valid, alu_result_q, store_data_q, wr_reg_q,
           reg_write_q, mem_read_q, mem_write_q, branch_taken, branch_target
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with BEQ resolution and wrong-path squash; 1-cycle latency.
// Stall holds every register (in_ready = !stall); flush overrides stall and clears valid/control.
module ex_mem_stage #(
  parameter int unsigned SHADOW = 2
) (
  input  logic          clk,
  input  logic          reset,
  ex_mem_stage_if.slave bus
);

  localparam logic [2:0] SHADOW_CNT = 3'(SHADOW);
  localparam logic [3:0] SEL_BEQ    = 4'b1000;

  typedef enum logic {
    S_RUN,
    S_SHADOW
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  wr_reg;
    logic [31:0] alu_result;
    logic [31:0] store_data;
  } mem_pkt_t;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  mem_pkt_t    pkt_q, pkt_d;
  logic        taken_q, taken_d;
  logic [31:0] target_q, target_d;

  logic        cap;
  logic        qv;
  logic        taken;
  logic [31:0] target_calc;

  always_comb begin
    cap         = !bus.stall && !bus.flush;
    qv          = bus.in_valid && (state_q == S_RUN);
    taken       = qv && bus.branch && (bus.selector == SEL_BEQ) && bus.zf;
    target_calc = bus.pc_plus4 + (bus.imm_ext << 2);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pkt_d    = pkt_q;
    // The taken pulse drops after one cycle whether or not the stage is stalled.
    taken_d  = 1'b0;
    target_d = target_q;

    if (bus.flush) begin
      pkt_d.valid     = 1'b0;
      pkt_d.reg_write = 1'b0;
      pkt_d.mem_read  = 1'b0;
      pkt_d.mem_write = 1'b0;
      state_d         = S_RUN;
      cnt_d           = 3'd0;
    end else if (cap) begin
      // Squashed or empty slots still load the data fields; only valid/control are masked.
      pkt_d.valid      = qv;
      pkt_d.reg_write  = qv && bus.reg_write && !bus.branch;
      pkt_d.mem_read   = qv && bus.mem_read;
      pkt_d.mem_write  = qv && bus.mem_write && !bus.branch;
      pkt_d.wr_reg     = bus.wr_reg;
      pkt_d.alu_result = bus.branch ? 32'd0 : bus.alu_result;
      pkt_d.store_data = bus.rt_data;
      taken_d          = taken;
      target_d         = target_calc;

      case (state_q)
        S_RUN: begin
          if (taken && (SHADOW_CNT != 3'd0)) begin
            state_d = S_SHADOW;
            cnt_d   = SHADOW_CNT;
          end
        end
        S_SHADOW: begin
          if (bus.in_valid) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q <= 3'd1) begin
              state_d = S_RUN;
              cnt_d   = 3'd0;
            end
          end
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      cnt_q    <= 3'd0;
      pkt_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pkt_q    <= pkt_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign bus.in_ready      = !bus.stall;
  assign bus.out_valid     = pkt_q.valid;
  assign bus.alu_result_q  = pkt_q.alu_result;
  assign bus.store_data_q  = pkt_q.store_data;
  assign bus.wr_reg_q      = pkt_q.wr_reg;
  assign bus.reg_write_q   = pkt_q.reg_write;
  assign bus.mem_read_q    = pkt_q.mem_read;
  assign bus.mem_write_q   = pkt_q.mem_write;
  assign bus.branch_taken  = taken_q;
  assign bus.branch_target = target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with SHADOW = 2; hand-computed expectations.
module tb_ex_mem_stage;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  ex_mem_stage_if bus ();

  ex_mem_stage #(.SHADOW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid   = 1'b0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.alu_result = 32'd0;
    bus.zf         = 1'b0;
    bus.selector   = 4'd0;
    bus.rt_data    = 32'd0;
    bus.wr_reg     = 5'd0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.branch     = 1'b0;
    bus.pc_plus4   = 32'd0;
    bus.imm_ext    = 32'd0;
  endtask

  task automatic set_add(input logic [31:0] res, input logic [4:0] rd);
    bus.in_valid   = 1'b1;
    bus.alu_result = res;
    bus.wr_reg     = rd;
    bus.reg_write  = 1'b1;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.branch     = 1'b0;
    bus.selector   = 4'b0010;
    bus.zf         = 1'b0;
    bus.rt_data    = res ^ 32'hA5A5_0000;
    bus.pc_plus4   = 32'h0000_0100;
    bus.imm_ext    = 32'd0;
  endtask

  task automatic set_beq(input logic [31:0] pc, input logic [31:0] imm, input logic z);
    bus.in_valid   = 1'b1;
    bus.branch     = 1'b1;
    bus.selector   = 4'b1000;
    bus.zf         = z;
    bus.pc_plus4   = pc;
    bus.imm_ext    = imm;
    bus.alu_result = 32'hDEAD_BEEF;
    bus.reg_write  = 1'b1;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b1;
    bus.wr_reg     = 5'd0;
    bus.rt_data    = 32'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu", bus.alu_result_q, 32'd0);
    chk("rst_store", bus.store_data_q, 32'd0);
    chk("rst_wr_reg", 32'(bus.wr_reg_q), 32'd0);
    chk("rst_reg_write", 32'(bus.reg_write_q), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read_q), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write_q), 32'd0);
    chk("rst_taken", 32'(bus.branch_taken), 32'd0);
    chk("rst_target", bus.branch_target, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);

    step();
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    set_add(32'h7, 5'd5);
    step();
    chk("add_out_valid", 32'(bus.out_valid), 32'd1);
    chk("add_alu", bus.alu_result_q, 32'h7);
    chk("add_wr_reg", 32'(bus.wr_reg_q), 32'd5);
    chk("add_reg_write", 32'(bus.reg_write_q), 32'd1);
    chk("add_taken", 32'(bus.branch_taken), 32'd0);
    chk("add_store", bus.store_data_q, 32'hA5A5_0007);

    set_add(32'h1000, 5'd2);
    bus.mem_read = 1'b1;
    step();
    chk("lw_mem_read", 32'(bus.mem_read_q), 32'd1);
    chk("lw_reg_write", 32'(bus.reg_write_q), 32'd1);

    set_add(32'h2000, 5'd0);
    bus.reg_write = 1'b0;
    bus.mem_write = 1'b1;
    bus.rt_data   = 32'h1234;
    step();
    chk("sw_mem_write", 32'(bus.mem_write_q), 32'd1);
    chk("sw_reg_write", 32'(bus.reg_write_q), 32'd0);
    chk("sw_mem_read", 32'(bus.mem_read_q), 32'd0);
    chk("sw_store", bus.store_data_q, 32'h1234);

    set_beq(32'h10, 32'hFFFF_FFFF, 1'b1);
    step();
    chk("beq_taken", 32'(bus.branch_taken), 32'd1);
    chk("beq_target", bus.branch_target, 32'hC);
    chk("beq_alu_zero", bus.alu_result_q, 32'd0);
    chk("beq_no_reg_write", 32'(bus.reg_write_q), 32'd0);
    chk("beq_no_mem_write", 32'(bus.mem_write_q), 32'd0);
    chk("beq_out_valid", 32'(bus.out_valid), 32'd1);
    chk("beq_cnt", 32'(dut.cnt_q), 32'd2);

    set_add(32'h11, 5'd6);
    step();
    chk("sq1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("sq1_reg_write", 32'(bus.reg_write_q), 32'd0);
    chk("sq1_taken_pulse", 32'(bus.branch_taken), 32'd0);
    chk("sq1_alu_loads", bus.alu_result_q, 32'h11);
    chk("sq1_cnt", 32'(dut.cnt_q), 32'd1);
    chk("sq1_target", bus.branch_target, 32'h100);

    bus.in_valid = 1'b0;
    step();
    chk("sq_idle_cnt", 32'(dut.cnt_q), 32'd1);
    chk("sq_idle_out_valid", 32'(bus.out_valid), 32'd0);

    set_add(32'h12, 5'd7);
    step();
    chk("sq2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("sq2_cnt", 32'(dut.cnt_q), 32'd0);

    set_add(32'h13, 5'd8);
    step();
    chk("post_sq_out_valid", 32'(bus.out_valid), 32'd1);
    chk("post_sq_alu", bus.alu_result_q, 32'h13);
    chk("post_sq_reg_write", 32'(bus.reg_write_q), 32'd1);

    set_beq(32'hFFFF_FFF0, 32'h8, 1'b0);
    step();
    chk("bne_taken", 32'(bus.branch_taken), 32'd0);
    chk("bne_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bne_target_wrap", bus.branch_target, 32'h10);
    chk("bne_cnt", 32'(dut.cnt_q), 32'd0);

    set_add(32'h22, 5'd8);
    step();
    chk("bne_next_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bne_next_alu", bus.alu_result_q, 32'h22);

    set_add(32'h33, 5'd9);
    bus.stall = 1'b1;
    #1;
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_alu_hold", bus.alu_result_q, 32'h22);
      chk("stall_wr_hold", 32'(bus.wr_reg_q), 32'd8);
      chk("stall_valid_hold", 32'(bus.out_valid), 32'd1);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_alu", bus.alu_result_q, 32'h33);
    chk("unstall_wr", 32'(bus.wr_reg_q), 32'd9);

    set_add(32'h44, 5'd10);
    bus.flush = 1'b1;
    step();
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_reg_write", 32'(bus.reg_write_q), 32'd0);
    chk("flush_alu_hold", bus.alu_result_q, 32'h33);
    chk("flush_wr_hold", 32'(bus.wr_reg_q), 32'd9);
    bus.flush = 1'b0;

    set_beq(32'h40, 32'h4, 1'b1);
    bus.stall = 1'b1;
    step();
    chk("beq_stall_taken", 32'(bus.branch_taken), 32'd0);
    chk("beq_stall_cnt", 32'(dut.cnt_q), 32'd0);
    bus.stall = 1'b0;
    step();
    chk("beq_release_taken", 32'(bus.branch_taken), 32'd1);
    chk("beq_release_target", bus.branch_target, 32'h50);
    chk("beq_release_cnt", 32'(dut.cnt_q), 32'd2);

    set_add(32'h55, 5'd11);
    bus.stall = 1'b1;
    step();
    chk("pulse_under_stall", 32'(bus.branch_taken), 32'd0);
    chk("shadow_stall_cnt1", 32'(dut.cnt_q), 32'd2);
    chk("shadow_stall_target", bus.branch_target, 32'h50);
    step();
    chk("shadow_stall_cnt2", 32'(dut.cnt_q), 32'd2);
    bus.stall = 1'b0;
    step();
    chk("shadow_sq_out_valid", 32'(bus.out_valid), 32'd0);
    chk("shadow_sq_cnt", 32'(dut.cnt_q), 32'd1);
    chk("shadow_sq_alu", bus.alu_result_q, 32'h55);

    set_add(32'h66, 5'd12);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    chk("fs_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fs_cnt", 32'(dut.cnt_q), 32'd0);
    chk("fs_alu_hold", bus.alu_result_q, 32'h55);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_add(32'h77, 5'd13);
    step();
    chk("fs_next_out_valid", 32'(bus.out_valid), 32'd1);
    chk("fs_next_alu", bus.alu_result_q, 32'h77);

    set_beq(32'h80, 32'h0, 1'b1);
    step();
    chk("rs_taken", 32'(bus.branch_taken), 32'd1);
    set_add(32'h88, 5'd14);
    step();
    chk("rs_cnt_before", 32'(dut.cnt_q), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rs_async_alu", bus.alu_result_q, 32'd0);
    chk("rs_async_target", bus.branch_target, 32'd0);
    chk("rs_async_wr", 32'(bus.wr_reg_q), 32'd0);
    chk("rs_async_cnt", 32'(dut.cnt_q), 32'd0);
    chk("rs_async_store", bus.store_data_q, 32'd0);
    #1 reset = 1'b0;
    set_add(32'h99, 5'd15);
    step();
    chk("rs_next_out_valid", 32'(bus.out_valid), 32'd1);
    chk("rs_next_alu", bus.alu_result_q, 32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
